// File: rtl/core_state_sequencer_if.sv
// Control bus between the scratchComputer core datapath and its stage sequencer.
// master drives run/handshake/decode inputs; slave (the sequencer) drives stage outputs.
interface core_state_sequencer_if;
  logic        run;
  logic        memReady;
  logic        memDataValid;
  logic        loadInstr;
  logic        storeInstr;
  logic        haltReq;
  logic        fetch_RequestState;
  logic        fetch_ReceiveState;
  logic        decodeState;
  logic        setupState;
  logic        executeState;
  logic        memReadState;
  logic        writebackState;
  logic        halted;
  logic        fault;
  logic [31:0] cycleCount;
  logic [31:0] instretCount;

  modport master (
    output run, memReady, memDataValid, loadInstr, storeInstr, haltReq,
    input  fetch_RequestState, fetch_ReceiveState, decodeState, setupState,
           executeState, memReadState, writebackState, halted, fault,
           cycleCount, instretCount
  );

  modport slave (
    input  run, memReady, memDataValid, loadInstr, storeInstr, haltReq,
    output fetch_RequestState, fetch_ReceiveState, decodeState, setupState,
           executeState, memReadState, writebackState, halted, fault,
           cycleCount, instretCount
  );
endinterface

// File: rtl/core_state_sequencer.sv
// Multi-cycle stage sequencer with memory-wait watchdog and halt handling.
// Optional cycle/instret counters are built when SEQ_PERF_COUNTERS_EN is defined.
//
// state     | meaning
// FETCH_REQ | issue instruction fetch, wait for run && memReady
// FETCH_RCV | wait for instruction data (memDataValid)
// DECODE    | decode instruction
// SETUP     | operand setup
// EXECUTE   | execute; loads/stores wait for memReady
// MEM_READ  | wait for load data (memDataValid)
// WRITEBACK | write result, retire, check haltReq
// HALTED    | terminal, left only by reset
// FAULT     | terminal, memory watchdog expired
module core_state_sequencer #(
  parameter int WAIT_LIMIT = 255,
  parameter int WAIT_W     = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  core_state_sequencer_if.slave seqBus
);

  typedef enum logic [3:0] {
    FETCH_REQ, FETCH_RCV, DECODE, SETUP, EXECUTE, MEM_READ, WRITEBACK, HALTED, FAULT
  } seqState_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  seqState_t         state, nextState;
  logic [WAIT_W-1:0] waitCnt, nextWaitCnt;
  logic [6:0]        stageQ, stageD;
  logic              waiting;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH_REQ;
      waitCnt <= '0;
      stageQ  <= 7'b000_0001;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
      stageQ  <= stageD;
    end
  end

  always_comb begin
    nextState   = state;
    nextWaitCnt = '0;
    waiting     = 1'b0;
    case (state)
      FETCH_REQ: begin
        waiting = seqBus.run;
        if (seqBus.run && seqBus.memReady) nextState = FETCH_RCV;
      end
      FETCH_RCV: begin
        waiting = 1'b1;
        if (seqBus.memDataValid) nextState = DECODE;
      end
      DECODE:  nextState = SETUP;
      SETUP:   nextState = EXECUTE;
      EXECUTE: begin
        // load has priority when both decode flags are set
        if (seqBus.loadInstr) begin
          waiting = 1'b1;
          if (seqBus.memReady) nextState = MEM_READ;
        end else if (seqBus.storeInstr) begin
          waiting = 1'b1;
          if (seqBus.memReady) nextState = WRITEBACK;
        end else begin
          nextState = WRITEBACK;
        end
      end
      MEM_READ: begin
        waiting = 1'b1;
        if (seqBus.memDataValid) nextState = WRITEBACK;
      end
      WRITEBACK: nextState = seqBus.haltReq ? HALTED : FETCH_REQ;
      default:   nextState = state;
    endcase

    // A handshake in the last allowed cycle has already moved nextState away.
    if (waiting && (nextState == state)) begin
      if (waitCnt == WAIT_LAST) nextState = FAULT;
      else                      nextWaitCnt = waitCnt + WAIT_W'(1);
    end
  end

  always_comb begin
    stageD = '0;
    case (nextState)
      FETCH_REQ: stageD[0] = 1'b1;
      FETCH_RCV: stageD[1] = 1'b1;
      DECODE:    stageD[2] = 1'b1;
      SETUP:     stageD[3] = 1'b1;
      EXECUTE:   stageD[4] = 1'b1;
      MEM_READ:  stageD[5] = 1'b1;
      WRITEBACK: stageD[6] = 1'b1;
      default:   stageD = '0;
    endcase
  end

  assign seqBus.fetch_RequestState = stageQ[0];
  assign seqBus.fetch_ReceiveState = stageQ[1];
  assign seqBus.decodeState        = stageQ[2];
  assign seqBus.setupState         = stageQ[3];
  assign seqBus.executeState       = stageQ[4];
  assign seqBus.memReadState       = stageQ[5];
  assign seqBus.writebackState     = stageQ[6];
  assign seqBus.halted             = (state == HALTED);
  assign seqBus.fault              = (state == FAULT);

`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] cycleCnt, instretCnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycleCnt   <= '0;
      instretCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (state == WRITEBACK) instretCnt <= instretCnt + 32'd1;
    end
  end

  assign seqBus.cycleCount   = cycleCnt;
  assign seqBus.instretCount = instretCnt;
`else
  assign seqBus.cycleCount   = '0;
  assign seqBus.instretCount = '0;
`endif

endmodule

// File: tb/tb_core_state_sequencer.sv
// Scoreboard bench for core_state_sequencer: stimulus pushes reference-model
// predictions per cycle, a monitor pops and compares after each rising edge.
module tb_core_state_sequencer;
  localparam int LIMIT = 4;
  localparam int WW    = 3;

  typedef struct packed {
    logic [6:0]  stages;
    logic        halted;
    logic        fault;
    logic [31:0] cyc;
    logic [31:0] ret;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  core_state_sequencer_if bus();

  core_state_sequencer #(.WAIT_LIMIT(LIMIT), .WAIT_W(WW)) dut (
    .clk(clk), .reset_n(reset_n), .seqBus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  obs_t expQ[$];

  // reference: stage index 0..6 = pipeline stages in order, 7 = halted, 8 = fault
  int          mSt;
  int          mWait;
  logic [31:0] mCyc, mRet;

  function automatic obs_t actual();
    obs_t o;
    o.stages = {bus.writebackState, bus.memReadState, bus.executeState, bus.setupState,
                bus.decodeState, bus.fetch_ReceiveState, bus.fetch_RequestState};
    o.halted = bus.halted;
    o.fault  = bus.fault;
    o.cyc    = bus.cycleCount;
    o.ret    = bus.instretCount;
    return o;
  endfunction

  function automatic obs_t predicted();
    obs_t o;
    o.stages = (mSt < 7) ? 7'(1 << mSt) : 7'd0;
    o.halted = (mSt == 7);
    o.fault  = (mSt == 8);
`ifdef SEQ_PERF_COUNTERS_EN
    o.cyc = mCyc;
    o.ret = mRet;
`else
    o.cyc = 32'd0;
    o.ret = 32'd0;
`endif
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = actual();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got stages=%b h=%b f=%b cyc=%0d ret=%0d want stages=%b h=%b f=%b cyc=%0d ret=%0d",
               name, $time, got.stages, got.halted, got.fault, got.cyc, got.ret,
               exp.stages, exp.halted, exp.fault, exp.cyc, exp.ret);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) check("cycle", expQ.pop_front());
  end

  task automatic modelReset();
    mSt = 0; mWait = 0; mCyc = '0; mRet = '0;
  endtask

  // one clock of stimulus; called at a falling edge, returns at the next one
  task automatic cyc(input bit run, input bit rdy, input bit dv,
                     input bit ld, input bit st, input bit hlt);
    bit adv, waitS;
    int succ;
    bus.run = run; bus.memReady = rdy; bus.memDataValid = dv;
    bus.loadInstr = ld; bus.storeInstr = st; bus.haltReq = hlt;
    adv = 1'b0; waitS = 1'b0; succ = mSt;
    case (mSt)
      0: begin waitS = run; adv = run && rdy; succ = 1; end
      1: begin waitS = 1; adv = dv; succ = 2; end
      2: begin adv = 1; succ = 3; end
      3: begin adv = 1; succ = 4; end
      4: begin
        if (ld)      begin waitS = 1; adv = rdy; succ = 5; end
        else if (st) begin waitS = 1; adv = rdy; succ = 6; end
        else         begin adv = 1; succ = 6; end
      end
      5: begin waitS = 1; adv = dv; succ = 6; end
      6: begin adv = 1; succ = hlt ? 7 : 0; end
      default: ;
    endcase
    mCyc = mCyc + 1;
    if (mSt == 6) mRet = mRet + 1;
    if (adv) begin
      mSt = succ; mWait = 0;
    end else if (waitS) begin
      if (mWait + 1 >= LIMIT) begin mSt = 8; mWait = 0; end
      else mWait = mWait + 1;
    end else begin
      mWait = 0;
    end
    expQ.push_back(predicted());
    @(negedge clk);
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // asynchronous reset in mid-cycle, released on a falling edge
  task automatic doReset();
    obs_t rv;
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    rv = predicted();
    check("reset", rv);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.run = 0; bus.memReady = 0; bus.memDataValid = 0;
    bus.loadInstr = 0; bus.storeInstr = 0; bus.haltReq = 0;
    modelReset();
    @(negedge clk);
    check("reset_initial", predicted());
    reset_n = 1'b1;

    // back-to-back ALU instructions, zero memory wait
    repeat (60) cyc(1, 1, 1, 0, 0, 0);
    doReset();

    // loads with read data arriving on the last allowed MEM_READ cycle
    repeat (40) cyc(1, 1, (mSt == 5) ? (mWait == LIMIT - 1) : 1'b1, 1, 0, 0);
    doReset();

    // instruction data never arrives: watchdog fault, then fault is sticky
    repeat (12) cyc(1, 1, 0, 0, 0, 0);
    repeat (20) cyc(pct(50), pct(50), pct(50), pct(50), pct(50), pct(50));
    doReset();

    // fetch data arriving on the last allowed FETCH_RCV cycle
    repeat (40) cyc(1, 1, (mSt == 1) ? (mWait == LIMIT - 1) : 1'b1, 0, pct(50), 0);
    doReset();

    // halt then sticky halted under random inputs
    repeat (12) cyc(1, 1, 1, 0, 0, 1);
    repeat (20) cyc(pct(50), pct(50), pct(50), pct(50), pct(50), pct(50));
    doReset();

    // parked core never faults, then resumes
    repeat (1000) cyc(0, 0, pct(50), 0, 0, 0);
    repeat (8) cyc(1, 1, 1, 0, 0, 0);

    // randomized blocks with varying memory responsiveness
    for (int blk = 0; blk < 24; blk++) begin
      int pm, ph;
      pm = (blk % 3 == 0) ? 25 : ((blk % 3 == 1) ? 60 : 90);
      ph = (blk % 4 == 0) ? 10 : 1;
      for (int i = 0; i < 120; i++)
        cyc(pct(90), pct(pm), pct(pm), pct(35), pct(35), pct(ph));
      doReset();
    end

    repeat (3) @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_state_sequencer.md
# core_state_sequencer

Multi-cycle control sequencer for the scratchComputer core: it generates the one-hot stage signals (fetch request, fetch receive, decode, setup, execute, memory read, writeback) that the frame write controller turns into frame-register write enables. It advances one stage per cycle in the internal stages and waits on the memory handshake in the fetch and memory stages. It also provides a memory-wait watchdog, halt handling and optional performance counters.

## Interface
- `WAIT_LIMIT`, default 255: maximum cycles spent waiting on memory before fault; must be ≥1.
- `WAIT_W`, default 8: width of the wait counter; must satisfy 2^WAIT_W > WAIT_LIMIT.
- `clk` input 1: single core clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `run` input 1: enables leaving FETCH_REQUEST; deassert to park the core between instructions.
- `memReady` input 1: memory accepted the current request (fetch or data access).
- `memDataValid` input 1: read data is present on the memory bus this cycle.
- `loadInstr` input 1: decoded instruction is a load; sampled in EXECUTE.
- `storeInstr` input 1: decoded instruction is a store; sampled in EXECUTE.
- `haltReq` input 1: halt request; sampled in WRITEBACK.
- `fetch_RequestState`, `fetch_ReceiveState`, `decodeState`, `setupState`, `executeState`, `memReadState`, `writebackState` output 1 each: one-hot stage indicators.
- `halted` output 1: core is in HALTED.
- `fault` output 1: core is in FAULT (memory watchdog expired).
- `cycleCount` output 32: free-running cycle counter (see Configuration).
- `instretCount` output 32: retired-instruction counter (see Configuration).

## Operation
- States: FETCH_REQ, FETCH_RCV, DECODE, SETUP, EXECUTE, MEM_READ, WRITEBACK, HALTED, FAULT.
- Each stage output is a registered decode of the state. At most one stage output is high in any cycle. All stage outputs are low in HALTED and FAULT.
- FETCH_REQ → FETCH_RCV when `run && memReady`. Otherwise the FSM stays in FETCH_REQ.
- FETCH_RCV → DECODE when `memDataValid`. Otherwise it stays.
- DECODE → SETUP and SETUP → EXECUTE unconditionally.
- EXECUTE:
  - If `loadInstr`: go to MEM_READ when `memReady`, otherwise stay.
  - Else if `storeInstr`: go to WRITEBACK when `memReady`, otherwise stay.
  - Else go to WRITEBACK.
  - If `loadInstr` and `storeInstr` are both high, the instruction is treated as a load.
- MEM_READ → WRITEBACK when `memDataValid`. Otherwise it stays.
- WRITEBACK → HALTED if `haltReq`, else → FETCH_REQ. An instruction retires on every cycle spent in WRITEBACK.
- HALTED and FAULT are terminal. Only `reset_n` leaves them.
- Watchdog:
  - `waitCnt` clears on every state change.
  - It increments each cycle the FSM stays in FETCH_REQ (only while `run` is high), FETCH_RCV, a memory-waiting EXECUTE, or MEM_READ.
  - When the FSM would stay in a waiting state and `waitCnt == WAIT_LIMIT-1`, the next state is FAULT.
  - A handshake arriving in that same cycle wins: the FSM takes the normal transition.
  - FETCH_REQ with `run` low never faults, and `waitCnt` holds at 0 there.

## Timing
- Reset values: state FETCH_REQ, so `fetch_RequestState`=1. All other stage outputs, `halted` and `fault` are 0. `waitCnt`, `cycleCount` and `instretCount` are 0.
- Deasserting `reset_n` mid-instruction aborts the instruction immediately, asynchronously. No retire is counted.
- Minimum instruction latency with zero memory wait is 6 cycles (FETCH_REQ, FETCH_RCV, DECODE, SETUP, EXECUTE, WRITEBACK). A load takes a minimum of 7 cycles.
- Handshake inputs are sampled on the same edge that leaves the waiting state. They have no effect in states that are not waiting on them.
- With `memReady` and `memDataValid` held high, `run` held high and no loads, the core retires one instruction every 6 cycles.

## Configuration
- `SEQ_PERF_COUNTERS_EN` defined:
  - `cycleCount` increments every cycle out of reset, including HALTED and FAULT.
  - `instretCount` increments on each WRITEBACK cycle.
  - Both wrap modulo 2^32.
- `SEQ_PERF_COUNTERS_EN` undefined: both counter ports are driven constant 0 and no counter registers exist.

## Test plan
- Reset, then `run`=1 and memory always ready/valid with non-memory instructions → stage outputs cycle FETCH_REQ, FETCH_RCV, DECODE, SETUP, EXECUTE, WRITEBACK with period 6. After 60 cycles `instretCount`=10 (macro on).
- Load with `memDataValid` delayed 3 cycles in MEM_READ → `memReadState` high for 4 cycles, then `writebackState` for 1 cycle. Total instruction latency 10 cycles.
- `memReady` held low in FETCH_RCV… more precisely, `memDataValid` held low in FETCH_RCV with `WAIT_LIMIT`=4 → FAULT entered after 4 cycles in FETCH_RCV: `fault`=1 and all stage outputs 0. FAULT is held until `reset_n` pulses low, after which `fetch_RequestState`=1.
- `memDataValid` rising in the cycle where `waitCnt`=WAIT_LIMIT-1 → normal transition to DECODE; `fault` stays 0.
- `haltReq`=1 during WRITEBACK → `halted`=1 on the next cycle; stays there regardless of `run` and memory inputs. `cycleCount` keeps incrementing and `instretCount` freezes.
- `run`=0 for 1000 cycles with `memReady`=0 → FSM stays in FETCH_REQ with no fault. After `run`=1 and `memReady`=1 it advances to FETCH_RCV on the next edge.
